instr_packer: RTL

Streaming RISC-V instruction encoder, the inverse of the core's immediate decode path. It accepts decoded fields (format, registers, funct, 32-bit immediate) over a valid/ready handshake and scatters the immediate into the correct bit positions for each format. It range-checks the fields and emits 32-bit instruction words through a 2-entry output buffer. Each word carries a word-aligned target address for instruction-memory loading, as used by the self-test program loader.

---
 rtl/rv_enc_pkg.sv | 26 ++
 rtl/packer_fifo2.sv | 55 +++++
 rtl/instr_packer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rv_enc_pkg.sv
// Shared encoding constants for the RISC-V instruction packer: field-bundle
// formats, major opcodes and the immediate ranges each format can hold.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_LOAD = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4
  } fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Signed 12-bit immediate (I, LOAD, S).
  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  // Branch byte offset: 13-bit signed, always even.
  localparam int signed IMMB_MIN  = -4096;
  localparam int signed IMMB_MAX  = 4094;

endpackage

// File: rtl/packer_fifo2.sv
// Two-entry FIFO for the packer output. The head entry is always visible on
// rdata, so the consumer sees a stable word while it stalls.
module packer_fifo2 #(
  parameter int                 DATA_W  = 64,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the two entries are reset because the head is a visible output
      // with a defined reset value; a deep RAM would normally not be reset.
      for (int i = 0; i < 2; i++) mem[i] <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, independent of statement order.
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_packer.sv
// Streaming RISC-V instruction encoder: scatters decoded fields into 32-bit
// instruction words, tags each with a word-aligned load address, and buffers
// them in a 2-entry FIFO. Optional immediate range checking is compiled in
// with the macro PACKER_RANGE_CHECK_EN.
module instr_packer
  import rv_enc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_range,
  output logic [7:0]        err_count
);

  localparam int ENTRY_W = 32 + ADDR_W;

  logic [31:0]       enc_word;
  logic              fmt_legal;
  logic              range_ok;
  logic              accept;
  logic              good;
  logic              reject;
  logic [ADDR_W-1:0] addr_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic signed [31:0] imm_s;

  assign imm_s = $signed(in_imm);

  // Encode mux: place fields and immediate bits according to the format.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred for the illegal formats.
    enc_word  = '0;
    fmt_legal = 1'b1;
    case (fmt_e'(in_fmt))
      FMT_I:    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
      FMT_LOAD: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
      FMT_S:    enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], OPC_STORE};
      FMT_B:    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OPC_BRANCH};
      FMT_U:    enc_word = {in_imm[31:12], in_rd, OPC_LUI};
      default:  fmt_legal = 1'b0;
    endcase
  end

`ifdef PACKER_RANGE_CHECK_EN
  // Immediate range check: the value must fit the format's field exactly.
  always_comb begin
    range_ok = 1'b1;
    case (fmt_e'(in_fmt))
      FMT_I, FMT_LOAD, FMT_S:
        range_ok = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
      FMT_B:
        range_ok = (imm_s >= IMMB_MIN) && (imm_s <= IMMB_MAX) && !in_imm[0];
      FMT_U:
        range_ok = (in_imm[11:0] == 12'h000);
      default: range_ok = 1'b1;
    endcase
  end
`else
  // Without checking, out-of-range immediates are truncated by the mux.
  assign range_ok = 1'b1;
`endif

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign good     = accept && fmt_legal && range_ok;
  assign reject   = accept && !(fmt_legal && range_ok);

  // Address counter: advances only for words that enter the buffer.
  always_ff @(posedge clk) begin
    if (rst)       addr_q <= BASE_ADDR;
    else if (good) addr_q <= addr_q + ADDR_W'(4);
  end

  // Sticky error flag and saturating rejection counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range <= 1'b0;
      err_count <= 8'd0;
    end else if (reject) begin
      err_range <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  packer_fifo2 #(
    .DATA_W  (ENTRY_W),
    .RST_VAL ({32'h0000_0000, BASE_ADDR})
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (good),
    .wdata ({enc_word, addr_q}),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = fifo_rdata[ENTRY_W-1:ADDR_W];
  assign out_addr  = fifo_rdata[ADDR_W-1:0];

endmodule
